axis_fifo_pkt: RTL
==================

Name: axis_fifo_pkt

Overview:
Parametrised synchronous AXI-stream FIFO with tlast support, an occupancy count and almost-full/almost-empty flags. It is built from inferred RAM rather than a vendor macro. With PACKET_MODE=1 the FIFO releases only complete packets. In that mode it also discards a packet flagged bad on its last beat, and discards any packet that overflows the FIFO. It sits between sample/packet producers and DMA or framing logic wherever packet atomicity is required.

Parameters:
DATA_WIDTH, 256, tdata width in bits.
FIFO_DEPTH, 16, number of entries; power of two, at least 4.
PACKET_MODE, 0, 0 = cut-through stream FIFO; 1 = store-and-forward with packet drop.
ALMOST_FULL, 14, almost_full asserts when count >= this value.
ALMOST_EMPTY, 2, almost_empty asserts when count <= this value.
(localparam AW = log2(FIFO_DEPTH))

Ports:
clk  in  1  core clock
rst_n  in  1  reset, asynchronous, active-low
s_axis_tvalid  in  1  slave valid
s_axis_tready  out  1  slave ready
s_axis_tdata  in  DATA_WIDTH  slave data
s_axis_tlast  in  1  end-of-packet marker
s_axis_tuser  in  1  bad-packet flag; sampled only on the tlast beat and only when PACKET_MODE=1
m_axis_tvalid  out  1  master valid
m_axis_tready  in  1  master ready
m_axis_tdata  out  DATA_WIDTH  master data
m_axis_tlast  out  1  stored tlast of the head entry
count  out  AW+1  entries held, including an uncommitted partial packet
almost_full  out  1  count >= ALMOST_FULL
almost_empty  out  1  count <= ALMOST_EMPTY
drop  out  1  one-cycle pulse when a packet is discarded

Behaviour:
- One clock (clk); reset rst_n is asynchronous and active-low.
- While rst_n is low:
  - outputs: s_axis_tready=0, m_axis_tvalid=0, count=0, almost_full=0, almost_empty=1, drop=0.
  - state: all pointers =0, FSM in ACCEPT.
- Pointers are AW+1 bits wide: wr_ptr (working), wr_cmt (committed), rd_ptr. Wrap is implicit modulo 2^(AW+1).
- Storage: mem[ptr[AW-1:0]] holds {tlast, tdata}. mem has no reset.
- Flags:
  - count = wr_ptr - rd_ptr.
  - full = (count == FIFO_DEPTH).
  - empty = (rd_ptr == wr_cmt).
  - count and flags derive from registered pointers only.
- Write: accepted when s_axis_tvalid & s_axis_tready.
  - Data is stored at wr_ptr, then wr_ptr increments.
  - A write is not accepted while full, even if a read occurs in the same cycle.
- Read: occurs when m_axis_tvalid & m_axis_tready, then rd_ptr increments.
  - m_axis_tvalid = ~empty.
  - m_axis_tdata and m_axis_tlast come combinationally from mem[rd_ptr] and are stable while valid & ~ready.
- Simultaneous accepted read and write: count is unchanged.
- PACKET_MODE=0:
  - wr_cmt follows wr_ptr every cycle; write-to-m_axis_tvalid latency is 1 cycle.
  - s_axis_tready = ~full.
  - tuser is ignored; drop stays 0.
- PACKET_MODE=1, FSM with states ACCEPT and DROP:
  - ACCEPT, s_axis_tready = ~full:
    - Accepted beat with tlast=1 and tuser=0: wr_cmt <= wr_ptr+1, so the whole packet becomes visible on the next cycle.
    - Accepted beat with tlast=1 and tuser=1: wr_ptr <= wr_cmt (rewind) and drop pulses. The packet is never visible.
    - full & s_axis_tvalid & (wr_ptr != wr_cmt), i.e. overflow mid-packet: wr_ptr <= wr_cmt, drop pulses, next state DROP. The current beat is not stored.
    - full with wr_ptr == wr_cmt (FIFO full of complete packets): tready stays 0; plain backpressure, no drop.
  - DROP, s_axis_tready = 1:
    - Every beat is discarded.
    - When a beat with tlast is accepted, return to ACCEPT. No second drop pulse is issued.
  - A packet longer than FIFO_DEPTH is therefore always dropped; the interface never deadlocks.
  - Rewind in the same cycle as a read is legal: count = rewound wr_ptr - new rd_ptr.
  - The master only sees whole, committed packets. A tlast=1 entry always ends each released packet.
- Asserting rst_n low mid-packet or mid-DROP discards all contents. The first beat after reset is treated as start of packet.

Test Plan:
1. PACKET_MODE=0, DEPTH=16; write 16 beats with data 0..15 and m_axis_tready=0 -> count=16, s_axis_tready=0, almost_full=1. Then hold m_axis_tready=1 -> data 0..15 in order, with tlast preserved.
2. PACKET_MODE=0; continuous write and read at count=8 -> count stays 8, no data lost. Also check the 1-cycle latency from the first write to m_axis_tvalid.
3. PACKET_MODE=1; send a 5-beat packet with m_axis_tready=1 -> m_axis_tvalid stays 0 until the cycle after the tlast beat. All 5 beats then emerge contiguously, with tlast on beat 5.
4. PACKET_MODE=1; send a 4-beat packet with tuser=1 on its last beat -> drop pulses once, count returns to its prior value, nothing is output. A following good packet is output intact.
5. PACKET_MODE=1, DEPTH=16, m_axis_tready=0; send a 20-beat packet -> drop pulses when beat 17 arrives, count returns to 0, and s_axis_tready=1 through beat 20. A following 3-beat packet is delivered.
6. Assert rst_n low mid-packet with 7 entries held -> outputs immediately take reset values. After release, count=0 and a fresh 2-beat packet passes.

Source files
------------

// File: rtl/axis_fifo_pkt_if.sv
// AXI-stream handshake bundle for axis_fifo_pkt.
// master drives the beat, slave returns tready.
interface axis_fifo_pkt_if #(
    parameter int unsigned DATA_WIDTH = 256
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic                  tuser;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_fifo_pkt.sv
// Synchronous AXI-stream FIFO on inferred RAM with occupancy flags.
// PACKET_MODE=1 releases only whole packets and drops bad or overflowing ones.
module axis_fifo_pkt #(
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter int unsigned PACKET_MODE  = 0,
    parameter int unsigned ALMOST_FULL  = 14,
    parameter int unsigned ALMOST_EMPTY = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    axis_fifo_pkt_if.slave                  s_axis,
    axis_fifo_pkt_if.master                 m_axis,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            almost_full,
    output logic                            almost_empty,
    output logic                            drop
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_LV = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] AF_LV    = (AW+1)'(ALMOST_FULL);
    localparam logic [AW:0] AE_LV    = (AW+1)'(ALMOST_EMPTY);

    typedef enum logic {
        ST_ACCEPT,
        ST_DROP
    } state_t;

    state_t state, state_nxt;

    logic [AW:0] wr_ptr, wr_ptr_nxt;
    logic [AW:0] wr_cmt, wr_cmt_nxt;
    logic [AW:0] rd_ptr;

    logic [DATA_WIDTH:0] mem [FIFO_DEPTH];

    logic full;
    logic empty;
    logic s_ready;
    logic wr_acc;
    logic rd_en;
    logic mem_we;
    logic drop_evt;

    // Occupancy counts the uncommitted tail; visibility is bounded by wr_cmt.
    assign count        = wr_ptr - rd_ptr;
    assign full         = (count == DEPTH_LV);
    assign empty        = (rd_ptr == wr_cmt);
    assign almost_full  = (count >= AF_LV);
    assign almost_empty = (count <= AE_LV);

    assign m_axis.tvalid = ~empty;
    assign m_axis.tuser  = 1'b0;
    assign {m_axis.tlast, m_axis.tdata} = mem[rd_ptr[AW-1:0]];
    assign rd_en = m_axis.tvalid & m_axis.tready;

    assign s_axis.tready = s_ready;
    assign drop          = drop_evt;

    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        wr_cmt_nxt = wr_cmt;
        s_ready    = rst_n & ~full;
        mem_we     = 1'b0;
        drop_evt   = 1'b0;
        wr_acc     = s_axis.tvalid & s_ready;

        if (PACKET_MODE == 0) begin
            mem_we = wr_acc;
            if (wr_acc) begin
                wr_ptr_nxt = wr_ptr + PTR_ONE;
            end
            wr_cmt_nxt = wr_ptr_nxt;
        end else begin
            unique case (state)
                ST_ACCEPT: begin
                    if (wr_acc) begin
                        if (s_axis.tlast && s_axis.tuser) begin
                            wr_ptr_nxt = wr_cmt;
                            drop_evt   = 1'b1;
                        end else begin
                            mem_we     = 1'b1;
                            wr_ptr_nxt = wr_ptr + PTR_ONE;
                            if (s_axis.tlast) begin
                                wr_cmt_nxt = wr_ptr + PTR_ONE;
                            end
                        end
                    end else if (full && s_axis.tvalid && (wr_ptr != wr_cmt)) begin
                        // Packet cannot fit: rewind and swallow the rest of it.
                        wr_ptr_nxt = wr_cmt;
                        drop_evt   = 1'b1;
                        state_nxt  = ST_DROP;
                    end
                end
                ST_DROP: begin
                    s_ready = rst_n;
                    if (s_axis.tvalid && s_axis.tlast) begin
                        state_nxt = ST_ACCEPT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_ACCEPT;
            wr_ptr <= '0;
            wr_cmt <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            wr_cmt <= wr_cmt_nxt;
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end
endmodule
